// File: rtl/rca_seq_ctrl.sv
// Wide-add sequencer: feeds an external W-bit ripple-carry slice one slice per clock, LSB first.
// Optional build macro SUBTRACT_EN adds port sub_i for modulo-2^N subtraction (a - b).
module rca_seq_ctrl #(
    parameter int W      = 4,
    parameter int SLICES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [W*SLICES-1:0]   a_i,
    input  logic [W*SLICES-1:0]   b_i,
    input  logic                  cin_i,
`ifdef SUBTRACT_EN
    input  logic                  sub_i,
`endif
    output logic                  busy_o,
    output logic                  done_o,
    output logic [W*SLICES-1:0]   sum_o,
    output logic                  cout_o,
    output logic [W-1:0]          add_a_o,
    output logic [W-1:0]          add_b_o,
    output logic                  add_cin_o,
    input  logic [W-1:0]          add_sum_i,
    input  logic                  add_cout_i
);

    localparam int N  = W * SLICES;
    localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   idx_q;
    logic [CW-1:0]   idx_d;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic            carry_q;
    logic            busy_q;
    logic            done_q;
    logic [N-1:0]    sum_q;
    logic            cout_q;

    logic            sub_s;
    logic            last_s;
    logic [N-1:0]    b_load_s;
    logic            cin_load_s;

`ifdef SUBTRACT_EN
    assign sub_s = sub_i;
`else
    assign sub_s = 1'b0;
`endif

    // Operand preparation and slice bookkeeping.
    always_comb begin
        idx_d      = idx_q + {{(CW-1){1'b0}}, 1'b1};
        last_s     = (idx_q == CW'(SLICES - 1));
        b_load_s   = b_i;
        cin_load_s = cin_i;
        if (sub_s) begin
            b_load_s   = ~b_i;
            cin_load_s = 1'b1;
        end else begin
            b_load_s   = b_i;
            cin_load_s = cin_i;
        end
    end

    // Sequencer FSM. Operand registers shift right one slice per RUN cycle, so their
    // low slice feeds the adder directly and they are naturally zero in IDLE/DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= S_RUN;
                        idx_q   <= '0;
                        a_q     <= a_i;
                        b_q     <= b_load_s;
                        carry_q <= cin_load_s;
                        busy_q  <= 1'b1;
                        sum_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    for (int s = 0; s < SLICES; s++) begin
                        if (idx_q == CW'(s)) begin
                            sum_q[s*W +: W] <= add_sum_i;
                        end
                    end
                    a_q   <= a_q >> W;
                    b_q   <= b_q >> W;
                    idx_q <= idx_d;
                    if (last_s) begin
                        // Final carry moves to cout; chain register cleared so add_cin_o idles at 0.
                        carry_q <= 1'b0;
                        cout_q  <= add_cout_i;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        carry_q <= add_cout_i;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign sum_o     = sum_q;
    assign cout_o    = cout_q;
    assign add_a_o   = a_q[W-1:0];
    assign add_b_o   = b_q[W-1:0];
    assign add_cin_o = carry_q;

endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
Sequencer that performs wide additions on a narrow ripple-carry adder slice. It adds W*SLICES-bit operands one W-bit slice per clock, least significant slice first, and chains each slice's carry into the next. The adder slice (e.g. the 4-bit RCA) sits outside this block and is driven through the add_* ports. A start/busy/done handshake connects it to the requesting logic.

Parameters:
W, 4, width of the external adder slice in bits
SLICES, 4, slices per operation; operand width N = W*SLICES (16 by default)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only when busy=0
a  in  N  operand A; sampled on the accepted start edge
b  in  N  operand B; sampled on the accepted start edge
cin  in  1  carry-in; sampled on the accepted start edge
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse when sum/cout become valid
sum  out  N  result; held until the next accepted start
cout  out  1  final carry; held until the next accepted start
add_a  out  W  slice operand A to the external adder
add_b  out  W  slice operand B to the external adder
add_cin  out  1  slice carry-in to the external adder
add_sum  in  W  slice sum from the adder (combinational, same cycle)
add_cout  in  1  slice carry-out from the adder (combinational, same cycle)

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, slice counter=0, carry register=0, operand registers=0. add_a, add_b and add_cin are 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches a, b and cin, clears the counter, clears sum, and moves to RUN.
  - busy goes to 1 after that edge.
- RUN, at slice index i (0..SLICES-1):
  - add_a = a_reg[i*W +: W] and add_b = b_reg[i*W +: W].
  - add_cin = cin_reg when i=0; otherwise the carry register.
  - At each edge: sum[i*W +: W] <= add_sum, carry <= add_cout, i <= i+1.
  - At the edge where i=SLICES-1: cout <= add_cout and the state moves to DONE.
- DONE:
  - Lasts exactly one cycle, with done=1 and busy=0. Then returns to IDLE.
  - A start sampled during DONE is accepted, so back-to-back operations are possible.
- Latency: start accepted at edge 0; done is high in the cycle after edge SLICES (4 for defaults). Throughput is one operation per SLICES+1 cycles.
- Start during RUN is ignored and does not extend or restart the operation. Operand inputs may change freely after acceptance.
- add_a, add_b and add_cin are driven to 0 in IDLE and DONE.
- sum and cout hold their last result through IDLE. sum is only partially updated (slice by slice) during RUN and is not valid until done.
- Arithmetic is modulo 2^N. The carry chain across slices is exact, so the result equals a+b+cin with cout as bit N.
- Reset asserted mid-operation aborts immediately to reset values, and no done pulse occurs. After release, the block waits in IDLE for a new start.
- SLICES=1 is legal: one RUN cycle, then DONE.

Optional Feature:
SUBTRACT_EN
- Defined:
  - Adds port sub (in, 1), latched with start.
  - When sub=1, add_b is the bitwise inverse of the b slice, and slice 0 carry-in is forced to 1 (cin ignored), so the result is a-b modulo 2^N.
  - cout=1 means no borrow (a>=b unsigned).
  - When sub=0, behaviour is identical to the plain build.
- Not defined: port sub does not exist; the block adds only.

Test Plan:
- Reset, then a=0x1234, b=0x4321, cin=0, start pulse -> busy for 4 cycles, done pulse in cycle 5, sum=0x5555, cout=0; add_* = 0 in IDLE and DONE.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; carry register = 1 after every slice (full chain propagation). Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Start a=0x0001, b=0x0001, then raise start again with a=0xAAAA in the 2nd RUN cycle -> second start ignored, result 0x0002; done pulses once.
- rst_n low during the 3rd RUN cycle -> busy, done, sum, cout = 0 immediately (asynchronously); no done pulse; next op a=0x00FF, b=0x0F01, cin=0 -> sum=0x1000, cout=0.
- Back-to-back: start held high through DONE with a=0x8000, b=0x8000 -> first result sum=0x0000, cout=1; second op accepted in the DONE cycle, done again 5 cycles later.
- SUBTRACT_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
